// File: rtl/fractal_sync_rf_sched.sv
// Shared barrier register file scheduler for one level of the fractal sync tree.
// Each requester port queues barrier indices in a small FIFO; a round-robin
// arbiter services one FIFO head per cycle with a read-modify-write on the
// addressed barrier entry. Wake/error responses pass through a service stage
// and an output stage, so they appear as single-cycle pulses two edges after
// the service decision is taken.
module fractal_sync_rf_sched #(
   parameter int N_PORTS    = 2,
   parameter int N_REGS     = 4,
   parameter int FIFO_DEPTH = 2,
   localparam int IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1,
   localparam int PID_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic [N_PORTS-1:0]       req_valid_i,
   output logic [N_PORTS-1:0]       req_ready_o,
   input  logic [N_PORTS*IDX_W-1:0] req_idx_i,
   output logic [N_PORTS-1:0]       rsp_valid_o,
   output logic [N_PORTS-1:0]       rsp_error_o,
   output logic [N_PORTS*IDX_W-1:0] rsp_idx_o,
   output logic                     busy_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [IDX_W-1:0]         fifo_mem  [N_PORTS][FIFO_DEPTH];
   logic [CNT_W-1:0]         fifo_cnt  [N_PORTS];
   logic [PTR_W-1:0]         fifo_head [N_PORTS];
   logic [PTR_W-1:0]         wr_ptr    [N_PORTS];
   logic [N_PORTS-1:0]       push;
   logic [N_PORTS-1:0]       pop;

   logic [PID_W-1:0]         rr_ptr;
   logic [N_REGS-1:0]        armed;
   logic [PID_W-1:0]         owner     [N_REGS];

   logic                     grant_valid;
   logic [PID_W-1:0]         grant_port;
   logic [PID_W-1:0]         cand;
   logic [IDX_W-1:0]         grant_idx;

   logic [CNT_W-1:0]         cnt_n     [N_PORTS];
   logic [PTR_W-1:0]         head_n    [N_PORTS];
   logic [N_REGS-1:0]        armed_n;
   logic [PID_W-1:0]         owner_n   [N_REGS];
   logic [PID_W-1:0]         ptr_n;
   logic                     busy_n;

   logic [N_PORTS-1:0]       svc_valid;
   logic [N_PORTS-1:0]       svc_error;
   logic [N_PORTS*IDX_W-1:0] svc_idx;
   logic [N_PORTS-1:0]       pend_valid;
   logic [N_PORTS-1:0]       pend_error;
   logic [N_PORTS*IDX_W-1:0] pend_idx;

   // Ready comes only from the registered count, so a full FIFO stays closed even when popped this cycle.
   always_comb begin
      for (int p = 0; p < N_PORTS; p++) begin
         req_ready_o[p] = (fifo_cnt[p] != CNT_W'(FIFO_DEPTH));
         push[p]        = req_valid_i[p] && req_ready_o[p];
         wr_ptr[p]      = PTR_W'((int'(fifo_head[p]) + int'(fifo_cnt[p])) % FIFO_DEPTH);
      end
   end

   // Round-robin pick of the first non-empty FIFO at or after the pointer; clear suppresses any grant.
   always_comb begin
      grant_valid = 1'b0;
      grant_port  = '0;
      cand        = '0;
      if (!clear_i) begin
         for (int k = 0; k < N_PORTS; k++) begin
            cand = PID_W'((int'(rr_ptr) + k) % N_PORTS);
            if (!grant_valid && (fifo_cnt[cand] != '0)) begin
               grant_valid = 1'b1;
               grant_port  = cand;
            end
         end
      end
      grant_idx = fifo_mem[grant_port][fifo_head[grant_port]];
   end

   // Next-state for FIFO bookkeeping, barrier entries, pointer and the service-stage response.
   always_comb begin
      armed_n   = armed;
      owner_n   = owner;
      ptr_n     = rr_ptr;
      svc_valid = '0;
      svc_error = '0;
      svc_idx   = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         pop[p]    = grant_valid && (grant_port == PID_W'(p));
         cnt_n[p]  = fifo_cnt[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
         head_n[p] = fifo_head[p];
         if (pop[p]) begin
            head_n[p] = (fifo_head[p] == PTR_W'(FIFO_DEPTH - 1)) ? '0 : fifo_head[p] + 1'b1;
         end
      end
      if (clear_i) begin
         armed_n = '0;
      end else if (grant_valid) begin
         ptr_n = (grant_port == PID_W'(N_PORTS - 1)) ? '0 : grant_port + 1'b1;
         if (int'(grant_idx) >= N_REGS) begin
            svc_valid[grant_port] = 1'b1;
            svc_error[grant_port] = 1'b1;
            svc_idx[int'(grant_port)*IDX_W +: IDX_W] = grant_idx;
         end else if (!armed[grant_idx]) begin
            armed_n[grant_idx] = 1'b1;
            owner_n[grant_idx] = grant_port;
         end else if (owner[grant_idx] == grant_port) begin
            svc_valid[grant_port] = 1'b1;
            svc_error[grant_port] = 1'b1;
            svc_idx[int'(grant_port)*IDX_W +: IDX_W] = grant_idx;
         end else begin
            armed_n[grant_idx] = 1'b0;
            svc_valid[grant_port] = 1'b1;
            svc_valid[owner[grant_idx]] = 1'b1;
            svc_idx[int'(grant_port)*IDX_W +: IDX_W] = grant_idx;
            svc_idx[int'(owner[grant_idx])*IDX_W +: IDX_W] = grant_idx;
         end
      end
      busy_n = |armed_n;
      for (int p = 0; p < N_PORTS; p++) begin
         if (cnt_n[p] != '0) busy_n = 1'b1;
      end
   end

   // FIFO storage needs no reset; occupancy is tracked by the counts.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < N_PORTS; p++) begin
         if (push[p]) fifo_mem[p][wr_ptr[p]] <= req_idx_i[p*IDX_W +: IDX_W];
      end
   end

   // Register all control state and both response stages; reset drops anything in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int p = 0; p < N_PORTS; p++) begin
            fifo_cnt[p]  <= '0;
            fifo_head[p] <= '0;
         end
         for (int r = 0; r < N_REGS; r++) owner[r] <= '0;
         armed       <= '0;
         rr_ptr      <= '0;
         pend_valid  <= '0;
         pend_error  <= '0;
         pend_idx    <= '0;
         rsp_valid_o <= '0;
         rsp_error_o <= '0;
         rsp_idx_o   <= '0;
         busy_o      <= 1'b0;
      end else begin
         fifo_cnt    <= cnt_n;
         fifo_head   <= head_n;
         armed       <= armed_n;
         owner       <= owner_n;
         rr_ptr      <= ptr_n;
         pend_valid  <= svc_valid;
         pend_error  <= svc_error;
         pend_idx    <= svc_idx;
         rsp_valid_o <= pend_valid;
         rsp_error_o <= pend_error;
         rsp_idx_o   <= pend_idx;
         busy_o      <= busy_n;
      end
   end

endmodule

// File: tb/tb_fractal_sync_rf_sched.sv
// Bench for fractal_sync_rf_sched: dutA uses four barrier entries, dutB uses
// three so that index 3 is illegal. Expected response pulses are queued when
// requests are driven and compared, with their due cycle, as they emerge.
module tb_fractal_sync_rf_sched;

   typedef struct {
      int         due;
      logic [1:0] v;
      logic [1:0] e;
      logic [3:0] idx;
   } rsp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic [1:0] reqValidA, reqReadyA, rspValidA, rspErrorA;
   logic [3:0] reqIdxA, rspIdxA;
   logic       busyA;
   logic [1:0] reqValidB, reqReadyB, rspValidB, rspErrorB;
   logic [3:0] reqIdxB, rspIdxB;
   logic       busyB;

   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   rsp_t qa[$];
   rsp_t qb[$];
   rsp_t expA, expB;
   int   t;

   fractal_sync_rf_sched #(.N_PORTS(2), .N_REGS(4), .FIFO_DEPTH(2)) dutA (
      .clk_i(clk), .rst_i(rst), .clear_i(clear),
      .req_valid_i(reqValidA), .req_ready_o(reqReadyA), .req_idx_i(reqIdxA),
      .rsp_valid_o(rspValidA), .rsp_error_o(rspErrorA), .rsp_idx_o(rspIdxA),
      .busy_o(busyA)
   );

   fractal_sync_rf_sched #(.N_PORTS(2), .N_REGS(3), .FIFO_DEPTH(2)) dutB (
      .clk_i(clk), .rst_i(rst), .clear_i(clear),
      .req_valid_i(reqValidB), .req_ready_o(reqReadyB), .req_idx_i(reqIdxB),
      .rsp_valid_o(rspValidB), .rsp_error_o(rspErrorB), .rsp_idx_o(rspIdxB),
      .busy_o(busyB)
   );

   // Free-running clock and an edge counter used to time responses.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Compare one emitted response pulse against the scoreboard entry it should match.
   task automatic compareRsp(input string tag, input rsp_t exp, input logic [1:0] v,
                             input logic [1:0] e, input logic [3:0] idx);
      checkOutput({tag, "_due"}, cyc, exp.due);
      checkOutput({tag, "_valid"}, {30'b0, v}, {30'b0, exp.v});
      checkOutput({tag, "_error"}, {30'b0, e & v}, {30'b0, exp.e});
      for (int p = 0; p < 2; p++) begin
         if (exp.v[p]) checkOutput($sformatf("%s_idx%0d", tag, p), {30'b0, idx[p*2 +: 2]}, {30'b0, exp.idx[p*2 +: 2]});
      end
   endtask

   // Drive one request cycle on dutA (sel=0) or dutB (sel=1); t returns the accepting edge.
   task automatic applyStimulus(input bit sel, input logic [1:0] v, input logic [3:0] idx, output int acc);
      if (!sel) begin reqValidA = v; reqIdxA = idx; end
      else      begin reqValidB = v; reqIdxB = idx; end
      @(posedge clk); #1;
      acc = cyc;
      reqValidA = 2'b00;
      reqValidB = 2'b00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic expectA(input int due, input logic [1:0] v, input logic [1:0] e, input logic [3:0] idx);
      rsp_t r;
      r.due = due; r.v = v; r.e = e; r.idx = idx;
      qa.push_back(r);
   endtask

   // Pop and compare whenever dutA emits a pulse; a pulse with nothing queued is a failure.
   always @(negedge clk) begin
      if (!rst && rspValidA != 2'b00) begin
         if (qa.size() == 0) checkOutput("rspA_unexpected", {30'b0, rspValidA}, 32'd0);
         else begin
            expA = qa.pop_front();
            compareRsp("rspA", expA, rspValidA, rspErrorA, rspIdxA);
         end
      end
   end

   // Same for dutB.
   always @(negedge clk) begin
      if (!rst && rspValidB != 2'b00) begin
         if (qb.size() == 0) checkOutput("rspB_unexpected", {30'b0, rspValidB}, 32'd0);
         else begin
            expB = qb.pop_front();
            compareRsp("rspB", expB, rspValidB, rspErrorB, rspIdxB);
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios; each ends with the DUT idle and the scoreboard drained.
   initial begin
      rst = 1'b1; clear = 1'b0;
      reqValidA = 2'b00; reqIdxA = 4'h0;
      reqValidB = 2'b00; reqIdxB = 4'h0;
      idle(2);
      checkOutput("reset_rsp_valid", {30'b0, rspValidA}, 32'd0);
      checkOutput("reset_ready", {30'b0, reqReadyA}, 32'd3);
      checkOutput("reset_busy", {31'b0, busyA}, 32'd0);
      checkOutput("reset_busy_b", {31'b0, busyB}, 32'd0);
      rst = 1'b0;
      idle(1);

      // Scenario 1: port0 waits on idx 2, port1 joins three edges later.
      applyStimulus(0, 2'b01, {2'd0, 2'd2}, t);
      expectA(t + 5, 2'b11, 2'b00, {2'd2, 2'd2});
      idle(1);
      checkOutput("s1_busy_waiting", {31'b0, busyA}, 32'd1);
      idle(1);
      applyStimulus(0, 2'b10, {2'd2, 2'd0}, t);
      idle(4);
      checkOutput("s1_busy_done", {31'b0, busyA}, 32'd0);
      checkOutput("s1_queue_empty", qa.size(), 32'd0);

      // Scenario 2: fresh reset, both ports request idx 1 together.
      rst = 1'b1; idle(1); rst = 1'b0;
      applyStimulus(0, 2'b11, {2'd1, 2'd1}, t);
      expectA(t + 3, 2'b11, 2'b00, {2'd1, 2'd1});
      idle(5);
      checkOutput("s2_busy_done", {31'b0, busyA}, 32'd0);
      checkOutput("s2_queue_empty", qa.size(), 32'd0);

      // Scenario 3: port0 re-arms its own entry (error), then port1 completes the pair.
      applyStimulus(0, 2'b01, {2'd0, 2'd1}, t);
      applyStimulus(0, 2'b01, {2'd0, 2'd1}, t);
      expectA(t + 2, 2'b01, 2'b01, {2'd0, 2'd1});
      applyStimulus(0, 2'b10, {2'd1, 2'd0}, t);
      expectA(t + 2, 2'b11, 2'b00, {2'd1, 2'd1});
      idle(4);
      checkOutput("s3_busy_done", {31'b0, busyA}, 32'd0);
      checkOutput("s3_queue_empty", qa.size(), 32'd0);

      // Scenario 4: dutB has three entries, so idx 3 is illegal and idx 2 is the last legal one.
      applyStimulus(1, 2'b10, {2'd3, 2'd0}, t);
      begin rsp_t r; r.due = t + 2; r.v = 2'b10; r.e = 2'b10; r.idx = {2'd3, 2'd0}; qb.push_back(r); end
      checkOutput("s4_busy_queued", {31'b0, busyB}, 32'd1);
      idle(4);
      checkOutput("s4_busy_after_error", {31'b0, busyB}, 32'd0);
      applyStimulus(1, 2'b01, {2'd0, 2'd2}, t);
      applyStimulus(1, 2'b10, {2'd2, 2'd0}, t);
      begin rsp_t r; r.due = t + 2; r.v = 2'b11; r.e = 2'b00; r.idx = {2'd2, 2'd2}; qb.push_back(r); end
      idle(4);
      checkOutput("s4_busy_done", {31'b0, busyB}, 32'd0);
      checkOutput("s4_queue_empty", qb.size(), 32'd0);

      // Scenario 5: clear held four cycles while port0 offers three requests to a depth-2 FIFO.
      applyStimulus(0, 2'b10, {2'd0, 2'd0}, t);
      idle(2);
      checkOutput("s5_armed_busy", {31'b0, busyA}, 32'd1);
      clear = 1'b1;
      reqValidA = 2'b01; reqIdxA = {2'd0, 2'd2};
      idle(1);
      checkOutput("s5_ready_one", {31'b0, reqReadyA[0]}, 32'd1);
      reqIdxA = {2'd0, 2'd3};
      idle(1);
      checkOutput("s5_ready_full", {31'b0, reqReadyA[0]}, 32'd0);
      reqIdxA = {2'd0, 2'd1};
      idle(1);
      checkOutput("s5_ready_held", {31'b0, reqReadyA[0]}, 32'd0);
      reqValidA = 2'b00;
      idle(1);
      checkOutput("s5_clear_no_pop", {31'b0, reqReadyA[0]}, 32'd0);
      clear = 1'b0;
      idle(1);
      checkOutput("s5_ready_after_pop", {31'b0, reqReadyA[0]}, 32'd1);
      idle(2);
      applyStimulus(0, 2'b10, {2'd0, 2'd0}, t);
      applyStimulus(0, 2'b01, {2'd0, 2'd0}, t);
      expectA(t + 2, 2'b11, 2'b00, {2'd0, 2'd0});
      applyStimulus(0, 2'b10, {2'd2, 2'd0}, t);
      expectA(t + 2, 2'b11, 2'b00, {2'd2, 2'd2});
      applyStimulus(0, 2'b10, {2'd3, 2'd0}, t);
      expectA(t + 2, 2'b11, 2'b00, {2'd3, 2'd3});
      idle(4);
      checkOutput("s5_busy_done", {31'b0, busyA}, 32'd0);
      checkOutput("s5_queue_empty", qa.size(), 32'd0);

      // Scenario 6: reset mid-cycle while port0 waits on idx 3 with an error in flight.
      applyStimulus(0, 2'b01, {2'd0, 2'd3}, t);
      idle(1);
      applyStimulus(0, 2'b01, {2'd0, 2'd3}, t);
      checkOutput("s6_busy_before", {31'b0, busyA}, 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("s6_reset_busy", {31'b0, busyA}, 32'd0);
      checkOutput("s6_reset_valid", {30'b0, rspValidA}, 32'd0);
      checkOutput("s6_reset_ready", {30'b0, reqReadyA}, 32'd3);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(3);
      applyStimulus(0, 2'b10, {2'd3, 2'd0}, t);
      idle(2);
      checkOutput("s6_rearmed_busy", {31'b0, busyA}, 32'd1);
      applyStimulus(0, 2'b01, {2'd0, 2'd3}, t);
      expectA(t + 2, 2'b11, 2'b00, {2'd3, 2'd3});
      idle(4);
      checkOutput("s6_busy_done", {31'b0, busyA}, 32'd0);
      checkOutput("s6_queue_empty", qa.size(), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
